onehot_pulse_decoder: RTL and testbench
=======================================

Name: onehot_pulse_decoder

Overview:
Sequential binary-to-one-hot decoder, the inverse of the 16-to-4 priority encoder used on the enable/encoder path. Accepts a 4-bit index over a valid/ready handshake and drives a registered 16-bit one-hot word for a programmable number of cycles. An optional idle gap follows each pulse. A one-entry buffer allows back-to-back codes without bubbles on the input side. Sits between control logic and per-channel strobes; it is a TMRG triplication test target.

Parameters:
BIN_W, 4, width of binary index; one-hot width N = 2**BIN_W
HOLD_CYCLES, 4, cycles the one-hot word is held (legal range >= 1)
GAP_CYCLES, 1, zero cycles forced between pulses (legal range >= 0; 0 means no gap)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable; low flushes all state synchronously
bin_in  input  BIN_W  binary index to decode
bin_valid  input  1  bin_in valid
bin_ready  output  1  block can accept; combinational = enable && !buf_valid
onehot_out  output  N  registered one-hot word, 1 << code, or all zero
onehot_valid  output  1  high while onehot_out is non-zero (HOLD state)
pulse_done  output  1  one-cycle registered strobe on the last HOLD cycle of each pulse
busy  output  1  (state != IDLE) || buf_valid

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, buf_valid 0, onehot_out 0, onehot_valid 0, pulse_done 0.
- Accept: a code is accepted at any rising edge where bin_valid && bin_ready.
- States:
  - IDLE: outputs zero. On accept, load onehot_out = 1 << bin_in directly, bypassing the buffer. Set counter = HOLD_CYCLES-1 and go to HOLD. Latency is one cycle: accepted at edge k, visible after edge k.
  - HOLD: onehot_out held and onehot_valid = 1. Counter decrements each cycle. pulse_done = 1 in the cycle where counter == 0.
    - At counter == 0 with GAP_CYCLES > 0: clear outputs, set counter = GAP_CYCLES-1, go to GAP.
    - At counter == 0 with GAP_CYCLES == 0: if buf_valid, load the buffered code and pop the buffer. Otherwise, if an accept occurs this edge, load bin_in. Otherwise go to IDLE. This gives back-to-back pulses with no zero cycle.
  - GAP: outputs zero. At counter == 0, apply the same next-code selection as above (load into HOLD), else go to IDLE.
- Buffer:
  - An accept during HOLD or GAP writes bin_in into the buffer and sets buf_valid.
  - bin_ready is low while the buffer is full, so an accept and a buffer pop never collide.
  - Ordering is strict FIFO. The buffered code is always older than any new input.
  - An accept on the same edge as a load with an empty buffer goes straight to the output register.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1). There is no wrap; it is reloaded on each state entry.
- Every index 0..N-1 is legal. Code 0 maps to 16'h0001 and code 15 maps to 16'h8000.
- enable low:
  - bin_ready is forced low.
  - At the next edge: state IDLE, buf_valid 0, outputs 0, pulse_done 0. Any in-flight pulse is truncated and the buffered code is discarded.
  - Behaviour resumes from IDLE when enable returns high.
- Reset mid-pulse clears immediately, asynchronously. The first cycle after release behaves as IDLE.
- An illegal parameter (HOLD_CYCLES < 1) is caught by an elaboration-time assertion.

Decomposition:
- Package onehot_pulse_pkg:
  - typedef enum logic [1:0] state_t {IDLE, HOLD, GAP}
  - function bin2onehot (binary index to one-hot word)
  - localparam for counter width computation
- No sub-module. It is a single always_ff for state, counter, buffer and outputs, plus an always_comb for next-state and ready. This keeps the structure flat for triplication and voter insertion.

Test Plan:
- Reset then single code 3 with HOLD=4, GAP=1 -> onehot_out = 16'h0008 for 4 cycles starting the cycle after accept. pulse_done is high on the 4th cycle. Then 1 zero cycle, then IDLE with busy = 0.
- Back-to-back codes 0, 15, 7 with bin_valid held high -> 16'h0001, 16'h8000, 16'h0080 in order, each for 4 cycles with 1-cycle gaps. bin_ready is low whenever the buffer holds a code. No code is lost or reordered.
- GAP_CYCLES=0 build, codes 5 then 6 -> 16'h0020 for 4 cycles immediately followed by 16'h0040 for 4 cycles, with no zero cycle between.
- enable dropped on the 2nd HOLD cycle of code 9 with code 2 buffered -> next edge onehot_out = 0, busy = 0, bin_ready = 0. After enable returns, code 2 is never emitted.
- rst_n asserted asynchronously mid-HOLD (between clock edges) -> outputs zero immediately. After release, code 12 yields 16'h1000 with normal 1-cycle latency.
- Exhaustive sweep of codes 0..15 -> each onehot_out equals 1 << code with exactly one bit set and onehot_valid matching.

Source files
------------

// File: rtl/onehot_pulse_pkg.sv
// rtl/onehot_pulse_pkg.sv - shared types and helpers for the one-hot pulse decoder
package onehot_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Widest binary index the decode helper supports
    localparam int MAX_BIN_W = 8;
    localparam int MAX_N     = 1 << MAX_BIN_W;

    // Binary index to one-hot word at the widest supported size; callers cast down
    function automatic logic [MAX_N-1:0] bin2onehot(input logic [MAX_BIN_W-1:0] idx);
        logic [MAX_N-1:0] word;
        word      = '0;
        word[idx] = 1'b1;
        return word;
    endfunction

    // Counter must hold the larger of the hold and gap reload values
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - binary index to timed one-hot pulse with one-entry input buffer
module onehot_pulse_decoder
    import onehot_pulse_pkg::*;
#(
    parameter int BIN_W       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic [(1<<BIN_W)-1:0] onehot_out,
    output logic                  onehot_valid,
    output logic                  pulse_done,
    output logic                  busy
);

    localparam int N     = 1 << BIN_W;
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Parameter sanity checks at elaboration
    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("onehot_pulse_decoder: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 0) begin : g_bad_gap
            $error("onehot_pulse_decoder: GAP_CYCLES must be >= 0");
        end
        if (BIN_W < 1 || BIN_W > MAX_BIN_W) begin : g_bad_binw
            $error("onehot_pulse_decoder: BIN_W out of supported range");
        end
    endgenerate

    function automatic logic [N-1:0] decode(input logic [BIN_W-1:0] code);
        return N'(bin2onehot(MAX_BIN_W'(code)));
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buf_valid_q, buf_valid_d;
    logic [BIN_W-1:0] buf_code_q, buf_code_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             onehot_valid_q, onehot_valid_d;
    logic             pulse_done_q, pulse_done_d;
    logic             accept;
    logic             pick_next;

    assign bin_ready    = enable && !buf_valid_q;
    assign accept       = bin_valid && bin_ready;
    assign onehot_out   = onehot_q;
    assign onehot_valid = onehot_valid_q;
    assign pulse_done   = pulse_done_q;
    assign busy         = (state_q != IDLE) || buf_valid_q;

    // Next-state, counter, buffer and output word selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_valid_d = buf_valid_q;
        buf_code_d  = buf_code_q;
        onehot_d    = onehot_q;
        pick_next   = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            buf_valid_d = 1'b0;
            onehot_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    onehot_d = '0;
                    if (accept) begin
                        onehot_d = decode(bin_in);
                        cnt_d    = HOLD_LOAD;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (accept) begin
                            buf_code_d  = bin_in;
                            buf_valid_d = 1'b1;
                        end
                    end else if (GAP_CYCLES > 0) begin
                        onehot_d = '0;
                        cnt_d    = GAP_LOAD;
                        state_d  = GAP;
                        if (accept) begin
                            buf_code_d  = bin_in;
                            buf_valid_d = 1'b1;
                        end
                    end else begin
                        pick_next = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (accept) begin
                            buf_code_d  = bin_in;
                            buf_valid_d = 1'b1;
                        end
                    end else begin
                        pick_next = 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    onehot_d = '0;
                end
            endcase

            // The buffered code is always older than bin_in, and bin_ready is
            // low while it is held, so the pop never races a new accept.
            if (pick_next) begin
                if (buf_valid_q) begin
                    onehot_d    = decode(buf_code_q);
                    buf_valid_d = 1'b0;
                    cnt_d       = HOLD_LOAD;
                    state_d     = HOLD;
                end else if (accept) begin
                    onehot_d = decode(bin_in);
                    cnt_d    = HOLD_LOAD;
                    state_d  = HOLD;
                end else begin
                    onehot_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
        end

        onehot_valid_d = (state_d == HOLD);
        pulse_done_d   = (state_d == HOLD) && (cnt_d == '0);
    end

    // All state, buffer and registered outputs in one flat register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            buf_valid_q    <= 1'b0;
            buf_code_q     <= '0;
            onehot_q       <= '0;
            onehot_valid_q <= 1'b0;
            pulse_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_valid_q    <= buf_valid_d;
            buf_code_q     <= buf_code_d;
            onehot_q       <= onehot_d;
            onehot_valid_q <= onehot_valid_d;
            pulse_done_q   <= pulse_done_d;
        end
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - scoreboard bench for onehot_pulse_decoder
module tb_onehot_pulse_decoder;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  bin_in;
    logic        bin_valid;
    logic        bin_ready;
    logic [15:0] onehot_out;
    logic        onehot_valid;
    logic        pulse_done;
    logic        busy;

    logic        b_enable;
    logic [3:0]  b_bin_in;
    logic        b_bin_valid;
    logic        b_bin_ready;
    logic [15:0] b_onehot_out;
    logic        b_onehot_valid;
    logic        b_pulse_done;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    onehot_pulse_decoder #(.BIN_W(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bin_in(bin_in),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .onehot_out(onehot_out),
        .onehot_valid(onehot_valid), .pulse_done(pulse_done), .busy(busy)
    );

    onehot_pulse_decoder #(.BIN_W(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .bin_in(b_bin_in),
        .bin_valid(b_bin_valid), .bin_ready(b_bin_ready), .onehot_out(b_onehot_out),
        .onehot_valid(b_onehot_valid), .pulse_done(b_pulse_done), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a code, wait for acceptance, and queue its expected output
    task automatic send(input logic [3:0] code);
        int n;
        n = 0;
        bin_in    = code;
        bin_valid = 1'b1;
        while (!bin_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_timeout", 32'(n < 200), 32'd1);
        exp_q.push_back(code);
        @(posedge clk); #1;
        bin_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(n < 500), 32'd1);
    endtask

    // Output monitor: pops the scoreboard at each pulse start and checks shape
    int          run = 0;
    int          zeros = 0;
    bit          had_pulse = 1'b0;
    bit          trunc = 1'b0;
    logic [15:0] cur = '0;

    always @(negedge clk) begin
        if (onehot_valid) begin
            if (run == 0) begin
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", 32'(onehot_out), 32'h0);
                    cur = onehot_out;
                end else begin
                    cur = 16'h0001 << exp_q.pop_front();
                    check("pulse_code", 32'(onehot_out), 32'(cur));
                end
                if (had_pulse) check("gap_min", 32'(zeros >= 1), 32'd1);
            end else begin
                check("pulse_hold", 32'(onehot_out), 32'(cur));
            end
            run++;
            check("pulse_done", 32'(pulse_done), 32'(run == HOLD));
            check("onehot_bits", 32'($countones(onehot_out)), 32'd1);
            zeros     = 0;
            had_pulse = 1'b1;
        end else begin
            if (run > 0 && !trunc) check("pulse_len", 32'(run), 32'(HOLD));
            if (run > 0) trunc = 1'b0;
            run = 0;
            zeros++;
            check("idle_zero", 32'(onehot_out), 32'h0);
            check("idle_done", 32'(pulse_done), 32'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        bin_in      = '0;
        bin_valid   = 1'b0;
        b_enable    = 1'b1;
        b_bin_in    = '0;
        b_bin_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_onehot", 32'(onehot_out), 32'h0);
        check("rst_valid", 32'(onehot_valid), 32'h0);
        check("rst_done", 32'(pulse_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(bin_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single code 3: one-cycle latency, 4-cycle hold, done on 4th, one gap cycle
        send(4'd3);
        check("t1_out_c1", 32'(onehot_out), 32'h0008);
        check("t1_done_c1", 32'(pulse_done), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1_out_c4", 32'(onehot_out), 32'h0008);
        check("t1_done_c4", 32'(pulse_done), 32'h1);
        @(posedge clk); #1;
        check("t1_gap_out", 32'(onehot_out), 32'h0);
        check("t1_gap_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Back-to-back 0, 15, 7 with bin_valid held
        send(4'd0);
        check("b2b_ready_empty", 32'(bin_ready), 32'h1);
        send(4'd15);
        check("b2b_ready_full", 32'(bin_ready), 32'h0);
        send(4'd7);
        wait_idle();

        // No-gap build: 5 then 6 run together without a zero cycle
        b_bin_in    = 4'd5;
        b_bin_valid = 1'b1;
        @(posedge clk); #1;
        b_bin_in = 4'd6;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("nogap_out_%0d", i), 32'(b_onehot_out),
                  (i < 4) ? 32'h0020 : (i < 8) ? 32'h0040 : 32'h0);
            check($sformatf("nogap_done_%0d", i), 32'(b_pulse_done),
                  32'((i == 3) || (i == 7)));
            @(posedge clk); #1;
            b_bin_valid = 1'b0;
        end
        check("nogap_busy", 32'(b_busy), 32'h0);

        // Enable drop on 2nd hold cycle of code 9 with code 2 buffered
        send(4'd9);
        send(4'd2);
        trunc = 1'b1;
        exp_q.delete();
        enable = 1'b0;
        #1;
        check("en_ready_low", 32'(bin_ready), 32'h0);
        @(posedge clk); #1;
        check("en_out", 32'(onehot_out), 32'h0);
        check("en_busy", 32'(busy), 32'h0);
        check("en_ready", 32'(bin_ready), 32'h0);
        check("en_valid", 32'(onehot_valid), 32'h0);
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("en_no_resume", 32'(busy), 32'h0);

        // Asynchronous reset between edges mid-hold
        send(4'd4);
        @(posedge clk);
        #3;
        trunc = 1'b1;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(onehot_out), 32'h0);
        check("arst_valid", 32'(onehot_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'd12);
        check("arst_code12", 32'(onehot_out), 32'h1000);
        check("arst_valid12", 32'(onehot_valid), 32'h1);
        wait_idle();

        // Sweep every code
        for (int c = 0; c < 16; c++) send(4'(c));
        wait_idle();
        check("sweep_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
